// File: rtl/echo_delay_if.sv
// Sample stream between the source, the echo_delay block and the output stage.
// x/x_valid/x_ready carry input samples in; y/y_valid carry mixed samples out.
interface echo_delay_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] x;
  logic                  x_valid;
  logic                  x_ready;
  logic [DATA_WIDTH-1:0] y;
  logic                  y_valid;

  modport master (output x, x_valid, input x_ready, y, y_valid);
  modport slave  (input x, x_valid, output x_ready, y, y_valid);
endinterface

// File: rtl/echo_delay.sv
// Feedback echo: circular buffer, run-time tap distance, dry/wet mix and feedback gain.
// Define ECHO_SAT_EN to saturate the sums instead of wrapping them.
module echo_delay #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE       = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int GAIN_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  rst,
  echo_delay_if.slave           s_if,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] delay_len,
  input  logic [GAIN_WIDTH-1:0] mix,
  input  logic [GAIN_WIDTH-1:0] fb_gain
);
  localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam int SW = DATA_WIDTH + 1;
  localparam int FW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    MAC   = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic signed [DATA_WIDTH-1:0]  x_q, x_d;
  logic                          en_q, en_d;
  logic [ADDR_WIDTH-1:0]         dly_q, dly_d;
  logic [GAIN_WIDTH-1:0]         mix_q, mix_d;
  logic [GAIN_WIDTH-1:0]         fbg_q, fbg_d;
  logic [ADDR_WIDTH-1:0]         wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]                 fill_q, fill_d;
  logic                          tap_zero_q, tap_zero_d;
  logic signed [DATA_WIDTH-1:0]  wet_q, wet_d;
  logic signed [DATA_WIDTH-1:0]  fbk_q, fbk_d;
  logic signed [DATA_WIDTH-1:0]  y_q, y_d;
  logic                          y_valid_q, y_valid_d;
  logic                          x_ready_q, x_ready_d;

  logic [DATA_WIDTH-1:0]         ram_q [SIZE];
  logic signed [DATA_WIDTH-1:0]  rd_data_q;

  logic                          accept_s;
  logic [ADDR_WIDTH-1:0]         rd_addr_s;
  logic signed [DATA_WIDTH-1:0]  d_s;
  logic signed [PW-1:0]          d_ext_s, mix_ext_s, fbg_ext_s;
  logic signed [PW-1:0]          prod_wet_s, prod_fbk_s;
  logic signed [SW-1:0]          sum_y_s, sum_fb_s;
  logic signed [DATA_WIDTH-1:0]  ram_wdata_s;
  logic                          ram_we_s;

  function automatic logic [DATA_WIDTH-1:0] lim(input logic [SW-1:0] s);
`ifdef ECHO_SAT_EN
    if (s[SW-1] != s[SW-2]) begin
      lim = s[SW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin
      lim = s[DATA_WIDTH-1:0];
    end
`else
    lim = DATA_WIDTH'(s);
`endif
  endfunction

  // Datapath: tap gating, gain products and the two limited sums.
  always_comb begin
    accept_s   = s_if.x_valid && x_ready_q;
    rd_addr_s  = wr_ptr_q - dly_q;
    d_s        = tap_zero_q ? '0 : rd_data_q;
    d_ext_s    = {{(GAIN_WIDTH+1){d_s[DATA_WIDTH-1]}}, d_s};
    mix_ext_s  = {{(DATA_WIDTH+1){1'b0}}, mix_q};
    fbg_ext_s  = {{(DATA_WIDTH+1){1'b0}}, fbg_q};
    prod_wet_s = d_ext_s * mix_ext_s;
    prod_fbk_s = d_ext_s * fbg_ext_s;
    sum_y_s    = {x_q[DATA_WIDTH-1], x_q} + {wet_q[DATA_WIDTH-1], wet_q};
    sum_fb_s   = {x_q[DATA_WIDTH-1], x_q} + {fbk_q[DATA_WIDTH-1], fbk_q};
    ram_we_s   = (state_q == WRITE);
    if (en_q) begin
      ram_wdata_s = lim(sum_fb_s);
    end else begin
      ram_wdata_s = x_q;
    end
  end

  // Next-state and registered-output logic for the four-phase sample sequence.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    en_d       = en_q;
    dly_d      = dly_q;
    mix_d      = mix_q;
    fbg_d      = fbg_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    tap_zero_d = tap_zero_q;
    wet_d      = wet_q;
    fbk_d      = fbk_q;
    y_d        = y_q;
    y_valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          x_d     = s_if.x;
          en_d    = en;
          dly_d   = delay_len;
          mix_d   = mix;
          fbg_d   = fb_gain;
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        // Unwritten slots may hold stale data from before reset; fill hides them.
        tap_zero_d = (dly_q == {ADDR_WIDTH{1'b0}}) || (fill_q < {1'b0, dly_q});
        state_d    = MAC;
      end
      MAC: begin
        wet_d   = DATA_WIDTH'(prod_wet_s >>> GAIN_WIDTH);
        fbk_d   = DATA_WIDTH'(prod_fbk_s >>> GAIN_WIDTH);
        state_d = WRITE;
      end
      WRITE: begin
        if (en_q) begin
          y_d = lim(sum_y_s);
        end else begin
          y_d = x_q;
        end
        y_valid_d = 1'b1;
        wr_ptr_d  = wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        if (fill_q != FW'(SIZE)) begin
          fill_d = fill_q + {{(FW-1){1'b0}}, 1'b1};
        end else begin
          fill_d = fill_q;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    x_ready_d = (state_d == IDLE);
  end

  // Control and datapath registers; everything returns to idle on reset.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      en_q       <= 1'b0;
      dly_q      <= '0;
      mix_q      <= '0;
      fbg_q      <= '0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      tap_zero_q <= 1'b1;
      wet_q      <= '0;
      fbk_q      <= '0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
      x_ready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      en_q       <= en_d;
      dly_q      <= dly_d;
      mix_q      <= mix_d;
      fbg_q      <= fbg_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      tap_zero_q <= tap_zero_d;
      wet_q      <= wet_d;
      fbk_q      <= fbk_d;
      y_q        <= y_d;
      y_valid_q  <= y_valid_d;
      x_ready_q  <= x_ready_d;
    end
  end

  // Sample buffer with registered read; contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (ram_we_s) begin
      ram_q[wr_ptr_q] <= ram_wdata_s;
    end
    if (state_q == READ) begin
      rd_data_q <= ram_q[rd_addr_s];
    end
  end

  assign s_if.x_ready = x_ready_q;
  assign s_if.y       = y_q;
  assign s_if.y_valid = y_valid_q;
endmodule

// File: doc/echo_delay.md
# echo_delay

Parametrised feedback echo for the guitar-effects datapath; successor to the fixed single-tap delay line. Keeps a circular sample buffer, reads a tap at a run-time selectable distance, and produces a dry/wet mixed output. The tap is also fed back into the buffer with a programmable gain. It sits between the sample source and the output stage and exchanges samples through a valid/ready handshake.

## Interface
- DATA_WIDTH, 32: signed two's-complement sample width.
- SIZE, 8: buffer depth in samples; must be a power of two.
- ADDR_WIDTH, 3: log2(SIZE).
- GAIN_WIDTH, 8: width of the unsigned Q0.GAIN_WIDTH gain inputs.
- CLK  in  1: single clock; all state changes on the rising edge.
- rst  in  1: asynchronous, active-low reset.
- x  in  DATA_WIDTH: input sample.
- x_valid  in  1: x is presented this cycle.
- x_ready  out  1: block can accept a sample.
- y  out  DATA_WIDTH: output sample, held until the next output.
- y_valid  out  1: one-cycle pulse marking a new y.
- en  in  1: 1 = effect active, 0 = bypass.
- delay_len  in  ADDR_WIDTH: tap distance in samples.
- mix  in  GAIN_WIDTH: wet gain, mix/2^GAIN_WIDTH.
- fb_gain  in  GAIN_WIDTH: feedback gain, fb_gain/2^GAIN_WIDTH.

## Operation
- FSM states: IDLE, READ, MAC, WRITE. x_ready = 1 only in IDLE.
- Accept: the sample is accepted when x_valid && x_ready at a rising edge. x, en, delay_len, mix and fb_gain are latched at that edge. Later changes to these inputs do not affect the sample in flight.
- IDLE → READ on accept. READ → MAC → WRITE → IDLE unconditionally.
- READ: buffer address = (wr_ptr − delay_len) mod SIZE; RAM has a registered read.
- Tap d:
  - d = 0 when delay_len == 0.
  - d = 0 when fill < delay_len, where fill counts writes since reset and saturates at SIZE.
  - Otherwise d = RAM data.
- MAC:
  - wet = (d × {0,mix}) >>> GAIN_WIDTH.
  - fbk = (d × {0,fb_gain}) >>> GAIN_WIDTH.
  - Products are signed, DATA_WIDTH+GAIN_WIDTH+1 bits; the arithmetic shift floors the result.
- WRITE:
  - Active (en = 1): ram[wr_ptr] = lim(x + fbk) and y = lim(x + wet).
  - Bypass (en = 0): ram[wr_ptr] = x and y = x.
  - Sums are DATA_WIDTH+1 bits; lim() reduces to DATA_WIDTH (see Configuration).
  - wr_ptr increments mod SIZE (wraps SIZE−1 → 0). fill increments until it reaches SIZE.
- Maximum usable delay is SIZE−1 samples.

## Timing
- Reset values: x_ready = 0 while rst is low; x_ready = 1 on the first edge after release. y = 0, y_valid = 0, wr_ptr = 0, fill = 0, state = IDLE. RAM contents are not cleared; the fill gating hides stale data.
- Latency: accept at edge k → y and y_valid update at edge k+3. y_valid is high for exactly one cycle.
- Throughput: one sample per 4 cycles. x_valid while x_ready = 0 is ignored; the source must hold x_valid until accepted.
- When y_valid is high, x_ready is high in the same cycle. Back-to-back accepts are therefore 4 cycles apart.
- Reset asserted mid-operation: the sample in flight is discarded and all state returns to reset values immediately. No y_valid pulse is produced for that sample.
- delay_len changed between samples: the new distance applies to the next accepted sample. No glitch output is produced.

## Configuration
- ECHO_SAT_EN defined: lim() saturates to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- ECHO_SAT_EN undefined: lim() truncates to the low DATA_WIDTH bits (two's-complement wrap).

## Test plan
All scenarios use DATA_WIDTH = 16, SIZE = 8, ADDR_WIDTH = 3, GAIN_WIDTH = 8.
- Reset/handshake: hold rst low, then release. Require y = 0, y_valid = 0, x_ready = 1. Accept a sample at edge k; require y_valid only at k+3 and x_ready = 0 for k+1..k+3 (states READ/MAC/WRITE).
- Impulse, no feedback: en = 1, delay_len = 3, mix = 128, fb_gain = 0, x = 1000 then zeros. Require y = 1000, 0, 0, 500, 0, 0, 0, …
- Feedback and wrap: same as the previous scenario but fb_gain = 128, for 12 samples. Require y = 1000, 0, 0, 500, 0, 0, 250, 0, 0, 125, … This crosses the wr_ptr wrap 7 → 0.
- Fill gating: after reset, delay_len = 7 with nonzero stale RAM, inputs x = 1..7. Require the first 7 outputs equal x exactly. Sample 8 requires y = 8 + floor(1·mix/256).
- Saturation: d = 32767, mix = 255, x = 32767. With ECHO_SAT_EN, require y = 32767. Without it, require y = −130.
- Bypass and reset mid-flight: en = 0, x = −5 gives y = −5 with the buffer written with −5. Pulse rst low in MAC; require no y_valid, fill = 0, and the next sample sees d = 0.
